mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 163 ++++++++++++++++
 tb/tb_mdu_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative M-extension sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_EARLY_OUT_EN to end a multiply as soon as the remaining multiplier bits are zero.
module mdu_seq #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, nextState;
    logic [CW-1:0]     cnt;
    logic [2:0]        opR;
    logic              wordR;
    logic [TAG_W-1:0]  tagR;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier, divisor, rem, quo, resR;
    logic              negRes, remNeg;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // ---------------- request decode and operand prep ----------------
    logic            accept, aSgn, bSgn, aNeg, bNeg, divZero, divOvf, special;
    logic [XLEN-1:0] aExt, bExt, aMag, bMag, aRaw, specRes;

    always_comb begin
        accept  = in_valid & in_ready & ~flush;
        aSgn    = ~in_op[0] | (in_op == 3'b001);
        bSgn    = aSgn & (in_op != 3'b010);
        aRaw    = in_word ? sext32(in_a[31:0]) : in_a;
        aExt    = in_word ? (aSgn ? sext32(in_a[31:0]) : {{(XLEN-32){1'b0}}, in_a[31:0]}) : in_a;
        bExt    = in_word ? (bSgn ? sext32(in_b[31:0]) : {{(XLEN-32){1'b0}}, in_b[31:0]}) : in_b;
        aNeg    = aSgn & aExt[XLEN-1];
        bNeg    = bSgn & bExt[XLEN-1];
        aMag    = aNeg ? -aExt : aExt;
        bMag    = bNeg ? -bExt : bExt;
        divZero = in_op[2] & (bExt == '0);
        divOvf  = in_op[2] & aSgn & (aExt == (in_word ? MIN_W : MIN_X)) & (bExt == '1);
        special = divZero | divOvf;
        // in_op[1] distinguishes rem/remu from div/divu
        if (divZero) specRes = in_op[1] ? aRaw : '1;
        else         specRes = in_op[1] ? '0 : aRaw;
    end

    // ---------------- per-bit step logic ----------------
    logic [2*XLEN-1:0] accNext;
    logic [XLEN:0]     shifted, trial;
    logic              qBit, earlyDone;

    always_comb begin
        accNext = mplier[0] ? acc + mcand : acc;
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        qBit    = ~trial[XLEN];
    end

`ifdef MDU_EARLY_OUT_EN
    // Bits above the one being consumed are all zero: the product is already complete.
    assign earlyDone = ~opR[2] & (mplier[XLEN-1:1] == '0);
`else
    assign earlyDone = 1'b0;
`endif

    // ---------------- sign correction and result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qFix, rFix, sel, fixRes;

    always_comb begin
        prod = negRes ? -acc : acc;
        qFix = negRes ? -quo : quo;
        rFix = remNeg ? -rem : rem;
        case (opR)
            3'b000:                 sel = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel = wordR ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel = qFix;
            default:                sel = rFix;
        endcase
        fixRes = wordR ? sext32(sel[31:0]) : sel;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = special ? DONE : CALC;
            CALC: if (flush) nextState = IDLE;
                  else if (cnt == CW'(1) || earlyDone) nextState = FIX;
            FIX:  nextState = flush ? IDLE : DONE;
            DONE: if (flush || out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    assign out_result = resR;
    assign out_tag    = tagR;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; opR <= '0; wordR <= 1'b0; tagR <= '0;
            acc <= '0; mcand <= '0; mplier <= '0; divisor <= '0;
            rem <= '0; quo <= '0; resR <= '0; negRes <= 1'b0; remNeg <= 1'b0;
        end else if (accept) begin
            opR     <= in_op;
            wordR   <= in_word;
            tagR    <= in_tag;
            cnt     <= in_word ? CW'(32) : CW'(XLEN);
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, aMag};
            mplier  <= bMag;
            divisor <= bMag;
            rem     <= '0;
            // left-align a word dividend so the divide always consumes from the MSB
            quo     <= in_word ? aMag << (XLEN-32) : aMag;
            negRes  <= aNeg ^ bNeg;
            remNeg  <= aNeg;
            if (special) resR <= specRes;
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (!opR[2]) begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                rem <= qBit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], qBit};
            end
        end else if (state == FIX && !flush) begin
            resR <= fixRes;
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table plus random ops against a reference model,
// scoreboarded, with hand sequences for backpressure, flush and reset.
module tb_mdu_seq;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_word, flush, out_valid, out_ready, busy;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;

    mdu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_word(in_word), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic             isMul;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] extOp(input logic w, input logic s, input logic [63:0] v);
        if (!w) return v;
        return s ? sx(v) : {32'b0, v[31:0]};
    endfunction

    function automatic logic [63:0] refModel(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic sa, sbn, ovf;
        logic [63:0] x, y, r;
        logic signed [127:0] px, py, p;
        sa  = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        sbn = op inside {3'd0, 3'd1, 3'd4, 3'd6};
        x   = extOp(w, sa, a);
        y   = extOp(w, sbn, b);
        px  = sa  ? {{64{x[63]}}, x} : {64'b0, x};
        py  = sbn ? {{64{y[63]}}, y} : {64'b0, y};
        p   = px * py;
        ovf = sa && (x == 64'h8000_0000_0000_0000) && (y == '1);
        case (op)
            3'd0: r = p[63:0];
            3'd1, 3'd2, 3'd3: r = w ? {32'b0, p[63:32]} : p[127:64];
            3'd4: begin
                if (y == 0) r = '1;
                else if (ovf) r = x;
                else r = $signed(x) / $signed(y);
            end
            3'd5: begin
                if (y == 0) r = '1;
                else r = x / y;
            end
            3'd6: begin
                if (y == 0) r = x;
                else if (ovf) r = '0;
                else r = $signed(x) % $signed(y);
            end
            default: begin
                if (y == 0) r = x;
                else r = x % y;
            end
        endcase
        return w ? sx(r) : r;
    endfunction

    function automatic int refLat(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
        logic sa;
        logic [63:0] x, y, mn;
        sa = (op == 3'd4) || (op == 3'd6);
        x  = extOp(w, sa, a);
        y  = extOp(w, sa, b);
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (op[2] && ((y == 0) || (sa && x == mn && y == '1))) return 1;
        return w ? 34 : 66;
    endfunction

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag,
                         input logic [63:0] res, input int lat);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout in_ready=%b expected=1", in_ready);
            return;
        end
        in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        e.res = res; e.tag = tag; e.lat = lat; e.isMul = ~op[2];
        sb.push_back(e);
    endtask

    // Called at the first negedge after the accept edge (latency 1).
    task automatic collect(input string name);
        int k = 1;
        exp_t e;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard empty queue size=0 expected>0", name);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout out_valid=0 expected=1", name);
            return;
        end
        chk({name, "_res"}, out_result, e.res);
        chk({name, "_tag"}, 64'(out_tag), 64'(e.tag));
`ifdef MDU_EARLY_OUT_EN
        if (!e.isMul) chk({name, "_lat"}, 64'(k), 64'(e.lat));
`else
        chk({name, "_lat"}, 64'(k), 64'(e.lat));
`endif
    endtask

    vec_t vecs[14];

    initial begin
        logic seen;
        vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[2]  = '{3'd1, 1'b0, '1, '1, 64'h0, 66};
        vecs[3]  = '{3'd5, 1'b0, 64'd100, 64'd0, '1, 1};
        vecs[4]  = '{3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1};
        vecs[5]  = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[6]  = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 34};
        vecs[7]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[8]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[9]  = '{3'd2, 1'b0, '1, 64'd2, '1, 66};
        vecs[10] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        vecs[11] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
        vecs[12] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34};
        vecs[13] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_word = 1'b0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", out_result, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].res, vecs[i].lat);
            collect($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
            issue(op, w, a, b, TAG_W'(i + 14), refModel(op, w, a, b), refLat(op, w, a, b));
            collect($sformatf("rnd%0d_op%0d_w%0d", i, op, w));
        end

        // Backpressure: result and tag must hold while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'd5, 1'b0, 64'd100, 64'd0, 5'd9, '1, 1);
        collect("bp");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_res", c), out_result, '1);
            chk($sformatf("bp_hold%0d_tag", c), 64'(out_tag), 64'd9);
            chk($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_in_ready", 64'(in_ready), 64'd1);
        chk("bp_after_valid", 64'(out_valid), 64'd0);

        // Flush coincident with in_valid in IDLE blocks the accept.
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd5; in_word = 1'b0; in_a = 64'd5; in_b = 64'd0;
        in_tag = 5'd21;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("idleflush_busy", 64'(busy), 64'd0);
        chk("idleflush_valid", 64'(out_valid), 64'd0);
        chk("idleflush_in_ready", 64'(in_ready), 64'd1);

        // Flush on CALC cycle 10.
        in_valid = 1'b1; in_op = 3'd0; in_word = 1'b0; in_a = 64'd3; in_b = '1; in_tag = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_busy_calc", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_out", 64'(seen), 64'd0);

        // Asynchronous reset mid-CALC.
        in_valid = 1'b1; in_op = 3'd4; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd7; in_tag = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_out", 64'(seen), 64'd0);

        issue(3'd0, 1'b0, 64'd5, 64'd6, 5'd30, 64'd30, 66);
        collect("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
